spawn_param_gen: RTL
====================

// Module: spawn_param_gen
// PURPOSE
//  Responder side of the object spawn handshake. An object state machine raises req when its object leaves
//  the screen. This block waits a pseudo-random number of frame ticks, then returns one randomized parameter
//  set: initial position, velocity, direction and sprite ROM start address. It then holds ack until req drops.
//  It sits beside each object state machine and feeds the motion and display blocks through that machine.
// PARAMETERS
//  DEPTH_BIT        18       sprite ROM address width
//  SEED             16'hACE1 LFSR reset value; must be nonzero
//  MIN_DELAY        8        minimum spawn delay in ticks; must be >=1
//  DELAY_RAND_BITS  6        random delay extension = lfsr[DELAY_RAND_BITS-1:0]; 0 gives a fixed delay
//  X_MIN            20       leftmost spawn x
//  X_RANGE          500      spawn-x span, 256..511
//  Y_SPAWN          375      spawn y (bottom of play field)
//  SPRITE_BASE      0        ROM address of sprite 0
//  SPRITE_STRIDE    8000     words per sprite (100x80)
// PORTS
//  clk        in   1          system clock
//  rstn       in   1          asynchronous active-low reset
//  tick       in   1          one-clk pulse per frame (motion tick)
//  req        in   1          spawn request (level, four-phase)
//  ack        out  1          parameter set valid; outputs stable while high
//  initposx   out  10         spawn x
//  initposy   out  10         spawn y
//  initvx     out  10         |vx|, 1..4
//  initvy     out  10         |vy| upward, 5..8
//  initdx     out  1          1 = move right
//  sprite_id  out  2          chosen sprite
//  addr       out  DEPTH_BIT  sprite ROM start address
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE, cnt=0, lfsr=SEED, ack=0, and every parameter output is 0.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, mask 16'hB400. It advances on every clk edge in every state.
//  FSM (ack = registered, high only in HOLD):
//   IDLE: req=1 -> WAIT; cnt <= MIN_DELAY + lfsr[DELAY_RAND_BITS-1:0] (12-bit, no overflow).
//   WAIT: req=0 -> IDLE (abort, no ack); else tick=1 & cnt==1 -> DRAW; else tick=1 -> cnt-1.
//   DRAW: snapshot r = lfsr; register every output from r; -> HOLD.
//   HOLD: ack=1. Outputs are frozen. req=0 -> IDLE and ack drops on that same edge.
//  Latency: ack rises 2 clk edges after the edge that samples the final tick.
//  If req and the final tick arrive on the same edge, req takes precedence: abort.
//  Arithmetic on snapshot r:
//   x9 = r[8:0]; if x9 >= X_RANGE then xo = x9 - X_RANGE, else xo = x9 (one conditional subtract).
//   initposx = X_MIN + xo, giving 20..519.
//   initdx   = (initposx < 320 - 50) ? 1 : 0, so the object drifts toward centre.
//   initvx   = 1 + r[10:9].
//   initvy   = 5 + r[12:11].
//   sprite_id = r[14:13].
//   addr     = SPRITE_BASE + sprite_id*SPRITE_STRIDE, truncated to DEPTH_BIT.
//   initposy = Y_SPAWN.
//  Parameter outputs keep their last values in IDLE/WAIT; they are only meaningful while ack=1.
//  A tick in IDLE/DRAW/HOLD is ignored. A reset mid-WAIT or mid-HOLD returns to reset values immediately.
// STRUCTURE
//  Shared package spawn_pkg holds:
//   - LFSR mask constant
//   - state encodings IDLE=0, WAIT=1, DRAW=2, HOLD=3
//   - function map_x(input [8:0]) implementing the conditional subtract plus X_MIN
//  Sub-module lfsr16 (clk, rstn, seed, out): free-running Galois LFSR.
//  FSM, counter and the output registers stay in the top module.
// TESTING
//  1. Assert rstn=0 mid-WAIT -> ack=0, all outputs 0 on the same cycle; after release, lfsr==SEED.
//  2. DELAY_RAND_BITS=0, MIN_DELAY=3, req=1 held, ticks every 10 clk -> ack rises exactly 2 clk after the 3rd tick.
//  3. Drop req after 1 tick of a 3-tick wait -> FSM returns to IDLE, ack never asserts; the next req restarts the full delay.
//  4. map_x in isolation: 0->20, 499->519, 500->20, 505->25, 511->31.
//  5. Hold req 5 clk after ack -> outputs unchanged. Drop req -> ack=0 next edge. Re-raise req -> new handshake.
//  6. 1000 spawns against a C/SV LFSR model -> every field matches the model; posx in 20..519, vx in 1..4,
//     vy in 5..8, addr in {0,8000,16000,24000}.

Source files
------------

// File: rtl/spawn_pkg.sv
// Shared constants and helpers for the object spawn parameter generator.
package spawn_pkg;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Handshake state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Default spawn-x window
    localparam int unsigned MAP_X_MIN   = 20;
    localparam int unsigned MAP_X_RANGE = 500;

    // Fold a 9-bit random value into the spawn-x window with a single
    // conditional subtract (x_range is at least 256, so one step suffices).
    function automatic logic [9:0] map_x(input logic [8:0] x9,
                                         input int unsigned x_min   = MAP_X_MIN,
                                         input int unsigned x_range = MAP_X_RANGE);
        logic [9:0] xo;
        if (10'(x9) >= 10'(x_range))
            xo = 10'(x9) - 10'(x_range);
        else
            xo = 10'(x9);
        return 10'(x_min) + xo;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, right-shifting, loads seed on reset.
module lfsr16
    import spawn_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    // Advance one step on every clock edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            out <= seed;
        else
            out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_MASK : 16'h0000);
    end

endmodule

// File: rtl/spawn_param_gen.sv
// Responder side of the object spawn handshake: waits a random number of
// frame ticks after req, then presents a randomized spawn parameter set and
// holds ack until req drops.
//
// state | meaning
// IDLE  | no request pending
// WAIT  | counting frame ticks down to the spawn
// DRAW  | latch parameter set from the current LFSR value
// HOLD  | parameters valid, ack high until req is released
module spawn_param_gen
    import spawn_pkg::*;
#(
    parameter int unsigned DEPTH_BIT       = 18,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int unsigned MIN_DELAY       = 8,
    parameter int unsigned DELAY_RAND_BITS = 6,
    parameter int unsigned X_MIN           = 20,
    parameter int unsigned X_RANGE         = 500,
    parameter int unsigned Y_SPAWN         = 375,
    parameter int unsigned SPRITE_BASE     = 0,
    parameter int unsigned SPRITE_STRIDE   = 8000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tick,
    input  logic                 req,
    output logic                 ack,
    output logic [9:0]           initposx,
    output logic [9:0]           initposy,
    output logic [9:0]           initvx,
    output logic [9:0]           initvy,
    output logic                 initdx,
    output logic [1:0]           sprite_id,
    output logic [DEPTH_BIT-1:0] addr
);

    // Mask rather than slice so a zero-width random extension stays legal
    localparam logic [15:0] RAND_MASK   = 16'((32'd1 << DELAY_RAND_BITS) - 32'd1);
    // Screen centre (320) minus half the sprite width (50)
    localparam logic [9:0]  DRIFT_SPLIT = 10'd270;

    logic [1:0]           state;
    logic [11:0]          cnt;
    logic [15:0]          lfsr;
    logic [11:0]          cnt_load;
    logic [9:0]           posx_next;
    logic [1:0]           sid_next;
    logic [DEPTH_BIT-1:0] addr_next;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .seed (SEED),
        .out  (lfsr)
    );

    // Delay load value and the parameter set derived from the live LFSR
    always_comb begin
        cnt_load  = 12'(MIN_DELAY) + 12'(lfsr & RAND_MASK);
        posx_next = map_x(lfsr[8:0], X_MIN, X_RANGE);
        sid_next  = lfsr[14:13];
        addr_next = DEPTH_BIT'(32'(SPRITE_BASE) + 32'(sid_next) * 32'(SPRITE_STRIDE));
    end

    // Handshake state machine and tick down-counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_WAIT;
                        cnt   <= cnt_load;
                    end
                end
                ST_WAIT: begin
                    if (!req)
                        state <= ST_IDLE;
                    else if (tick && cnt == 12'd1)
                        state <= ST_DRAW;
                    else if (tick)
                        cnt <= cnt - 12'd1;
                end
                ST_DRAW: state <= ST_HOLD;
                ST_HOLD: begin
                    if (!req)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ack rises one edge into HOLD and falls on the edge that leaves it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ack <= 1'b0;
        else
            ack <= (state == ST_HOLD) && req;
    end

    // Snapshot the parameter set in DRAW; held unchanged everywhere else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            initposx  <= '0;
            initposy  <= '0;
            initvx    <= '0;
            initvy    <= '0;
            initdx    <= 1'b0;
            sprite_id <= '0;
            addr      <= '0;
        end else if (state == ST_DRAW) begin
            initposx  <= posx_next;
            initposy  <= 10'(Y_SPAWN);
            initvx    <= 10'd1 + 10'(lfsr[10:9]);
            initvy    <= 10'd5 + 10'(lfsr[12:11]);
            initdx    <= (posx_next < DRIFT_SPLIT);
            sprite_id <= sid_next;
            addr      <= addr_next;
        end
    end

endmodule
